program_counter_fetch: RTL and testbench



---
 rtl/program_counter_fetch.sv | 105 ++++++++++
 tb/tb_program_counter_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter_fetch.sv
// Instruction-fetch stage: owns PC and IR, fetches over a req/ack memory port
// and hands each instruction to the datapath over a valid/ready issue port.
module program_counter_fetch #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        PL,
   input  logic        JB,
   input  logic        BC,
   input  logic        Z,
   input  logic        N,
   input  logic [15:0] bus_a,
   output logic [15:0] pc,
   output logic [1:0]  state_dbg
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;

   logic [15:0] branch_off;
   logic [15:0] pc_inc;
   logic [15:0] pc_branch;
   logic        branch_cond;
   logic [15:0] pc_next;

   // Branch offset {instr[8:6], instr[2:0]} is a 6-bit two's-complement value
   // relative to the branch's own PC; all sums wrap modulo 2^16.
   assign branch_off  = {{10{ir_q[8]}}, ir_q[8:6], ir_q[2:0]};
   assign pc_inc      = pc_q + 16'd1;
   assign pc_branch   = pc_q + branch_off;
   assign branch_cond = BC ? N : Z;

   always_comb begin
      pc_next = pc_inc;
      if (PL) begin
         if (JB) begin
            pc_next = bus_a;
         end else if (branch_cond) begin
            pc_next = pc_branch;
         end
      end
   end

   // Handshakes: a memory word transfers on an edge where imem_req && imem_ack;
   // an instruction is consumed on an edge where instr_valid && instr_ready.
   // Each side's input is ignored while its own valid/request is low.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_data;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (instr_ready) begin
               pc_d    = pc_next;
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_VECTOR;
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   assign imem_req    = (state_q == ST_FETCH);
   assign instr_valid = (state_q == ST_ISSUE);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = ir_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_program_counter_fetch.sv
// Self-checking bench for program_counter_fetch: directed scenarios plus a
// randomized instruction stream checked against a next-PC reference model.
module tb_program_counter_fetch;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        PL, JB, BC, Z, N;
   logic [15:0] bus_a;
   logic [15:0] pc;
   logic [1:0]  state_dbg;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   program_counter_fetch #(.RESET_VECTOR(16'h0000)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .PL(PL), .JB(JB), .BC(BC), .Z(Z), .N(N), .bus_a(bus_a),
      .pc(pc), .state_dbg(state_dbg)
   );

   // Next PC from the architectural rules, using integer arithmetic mod 65536.
   function automatic logic [15:0] model_next_pc(input logic [15:0] cur_pc, input logic [15:0] word,
                                                 input logic pl, input logic jb, input logic bc,
                                                 input logic z, input logic n, input logic [15:0] tgt);
      int field;
      int off;
      int sum;
      if (!pl) return 16'((int'(cur_pc) + 1) % 65536);
      if (jb) return tgt;
      if (!(bc ? n : z)) return 16'((int'(cur_pc) + 1) % 65536);
      field = int'(word[8:6]) * 8 + int'(word[2:0]);
      off   = (field >= 32) ? field - 64 : field;
      sum   = (int'(cur_pc) + off + 65536) % 65536;
      return 16'(sum);
   endfunction

   task automatic drive_fetch(input logic [15:0] word, input int stall);
      repeat (stall) begin
         imem_ack  = 1'b0;
         imem_data = 16'($urandom);
         @(negedge clk);
      end
      imem_ack  = 1'b1;
      imem_data = word;
      @(negedge clk);
      imem_ack  = 1'b0;
      imem_data = 16'($urandom);
   endtask

   task automatic drive_issue(input logic pl, input logic jb, input logic bc, input logic z,
                              input logic n, input logic [15:0] tgt, input int stall);
      repeat (stall) begin
         instr_ready = 1'b0;
         PL = 1'($urandom); JB = 1'($urandom); BC = 1'($urandom);
         Z  = 1'($urandom); N  = 1'($urandom); bus_a = 16'($urandom);
         @(negedge clk);
      end
      instr_ready = 1'b1;
      PL = pl; JB = jb; BC = bc; Z = z; N = n; bus_a = tgt;
      @(negedge clk);
      instr_ready = 1'b0;
      PL = 1'b0; JB = 1'b0; BC = 1'b0; Z = 1'b0; N = 1'b0; bus_a = 16'h0000;
   endtask

   task automatic goto_pc(input logic [15:0] addr);
      drive_fetch(16'hE018, 0);
      drive_issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, addr, 0);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests_run++; if (pc !== 16'h0000) begin tests_failed++; $display("FAIL reset_pc: got %h expected %h", pc, 16'h0000); end
      tests_run++; if (imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 16'h0000); end
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", imem_req); end
      tests_run++; if (instr !== 16'h0000) begin tests_failed++; $display("FAIL reset_instr: got %h expected %h", instr, 16'h0000); end
      tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
      tests_run++; if (state_dbg !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
      reset = 1'b0;
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL first_fetch: req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr); end
   endtask

   task automatic test_linear();
      for (int i = 0; i < 4; i++) begin
         tests_run++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 16'(i)) begin tests_failed++; $display("FAIL linear_fetch[%0d]: req=%b valid=%b addr=%h expected req=1 valid=0 addr=%h", i, imem_req, instr_valid, imem_addr, 16'(i)); end
         imem_ack = 1'b1; imem_data = 16'h0000;
         @(negedge clk);
         imem_ack = 1'b0;
         tests_run++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL linear_issue[%0d]: valid=%b req=%b expected valid=1 req=0", i, instr_valid, imem_req); end
         instr_ready = 1'b1; PL = 1'b0;
         @(negedge clk);
         instr_ready = 1'b0;
      end
      tests_run++; if (imem_addr !== 16'h0004) begin tests_failed++; $display("FAIL linear_end: got %h expected %h", imem_addr, 16'h0004); end
   endtask

   task automatic test_brz();
      goto_pc(16'h0010);
      tests_run++; if (imem_addr !== 16'h0010) begin tests_failed++; $display("FAIL brz_setup: got %h expected %h", imem_addr, 16'h0010); end
      drive_fetch(16'hC1C6, 1);
      tests_run++; if (instr !== 16'hC1C6) begin tests_failed++; $display("FAIL brz_instr: got %h expected %h", instr, 16'hC1C6); end
      drive_issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'($urandom), 0);
      tests_run++; if (imem_addr !== 16'h000E) begin tests_failed++; $display("FAIL brz_taken: got %h expected %h", imem_addr, 16'h000E); end
      goto_pc(16'h0010);
      drive_fetch(16'hC1C6, 0);
      drive_issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'($urandom), 0);
      tests_run++; if (imem_addr !== 16'h0011) begin tests_failed++; $display("FAIL brz_not_taken: got %h expected %h", imem_addr, 16'h0011); end
   endtask

   task automatic test_brn_wrap();
      goto_pc(16'hFFFE);
      drive_fetch(16'hC203, 0);
      drive_issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'($urandom), 0);
      tests_run++; if (imem_addr !== 16'h0001) begin tests_failed++; $display("FAIL brn_wrap: got %h expected %h", imem_addr, 16'h0001); end
      goto_pc(16'hFFFE);
      drive_fetch(16'h0000, 0);
      drive_issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom), 0);
      tests_run++; if (imem_addr !== 16'hFFFF) begin tests_failed++; $display("FAIL inc_ffff: got %h expected %h", imem_addr, 16'hFFFF); end
      drive_fetch(16'h0000, 0);
      drive_issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom), 0);
      tests_run++; if (imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL inc_wrap: got %h expected %h", imem_addr, 16'h0000); end
   endtask

   task automatic test_jmp();
      drive_fetch(16'hE018, 0);
      drive_issue(1'b1, 1'b1, 1'($urandom), 1'b1, 1'b1, 16'h1234, 0);
      tests_run++; if (imem_addr !== 16'h1234 || pc !== 16'h1234 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL jmp: addr=%h pc=%h req=%b expected 1234 1234 1", imem_addr, pc, imem_req); end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 5; i++) begin
         imem_ack = 1'b0; instr_ready = 1'b1; PL = 1'b1; JB = 1'b1; bus_a = 16'($urandom);
         @(negedge clk);
         tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h1234 || pc !== 16'h1234 || instr !== 16'hE018) begin tests_failed++; $display("FAIL ack_stall[%0d]: req=%b addr=%h pc=%h instr=%h expected 1 1234 1234 e018", i, imem_req, imem_addr, pc, instr); end
      end
      instr_ready = 1'b0; PL = 1'b0; JB = 1'b0;
      imem_ack = 1'b1; imem_data = 16'h0A5A;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         instr_ready = 1'b0; imem_ack = 1'b1; imem_data = 16'($urandom);
         PL = 1'b1; JB = 1'b1; bus_a = 16'($urandom);
         @(negedge clk);
         tests_run++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 16'h0A5A || pc !== 16'h1234) begin tests_failed++; $display("FAIL ready_stall[%0d]: valid=%b req=%b instr=%h pc=%h expected 1 0 0a5a 1234", i, instr_valid, imem_req, instr, pc); end
      end
      imem_ack = 1'b0; instr_ready = 1'b1; PL = 1'b0; JB = 1'b0;
      @(negedge clk);
      instr_ready = 1'b0;
      tests_run++; if (imem_addr !== 16'h1235 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL bp_advance: addr=%h req=%b expected 1235 1", imem_addr, imem_req); end
      @(negedge clk);
      tests_run++; if (imem_addr !== 16'h1235) begin tests_failed++; $display("FAIL bp_single_advance: got %h expected %h", imem_addr, 16'h1235); end
   endtask

   task automatic test_reset_mid();
      goto_pc(16'h0700);
      imem_ack = 1'b1; imem_data = 16'hABCD; reset = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      tests_run++; if (pc !== 16'h0000 || instr !== 16'h0000 || imem_req !== 1'b0 || instr_valid !== 1'b0 || state_dbg !== ST_IDLE) begin tests_failed++; $display("FAIL reset_in_fetch: pc=%h instr=%h req=%b valid=%b state=%0d expected 0000 0000 0 0 0", pc, instr, imem_req, instr_valid, state_dbg); end
      reset = 1'b0;
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || state_dbg !== ST_FETCH) begin tests_failed++; $display("FAIL refetch_after_fetch_reset: req=%b addr=%h expected 1 0000", imem_req, imem_addr); end
      goto_pc(16'h0700);
      drive_fetch(16'h1111, 0);
      instr_ready = 1'b1; PL = 1'b1; JB = 1'b1; bus_a = 16'h5555; reset = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0; PL = 1'b0; JB = 1'b0;
      tests_run++; if (pc !== 16'h0000 || instr !== 16'h0000 || imem_req !== 1'b0 || instr_valid !== 1'b0 || state_dbg !== ST_IDLE) begin tests_failed++; $display("FAIL reset_in_issue: pc=%h instr=%h req=%b valid=%b state=%0d expected 0000 0000 0 0 0", pc, instr, imem_req, instr_valid, state_dbg); end
      reset = 1'b0;
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL refetch_after_issue_reset: req=%b addr=%h expected 1 0000", imem_req, imem_addr); end
   endtask

   task automatic test_random();
      logic [15:0] model_pc;
      logic [15:0] word, tgt, expected;
      logic pl, jb, bc, z, n;
      model_pc = 16'h0000;
      exp_q.push_back(model_pc);
      for (int i = 0; i < 150; i++) begin
         expected = exp_q.pop_front();
         tests_run++; if (imem_addr !== expected || imem_req !== 1'b1 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rand_fetch[%0d]: addr=%h req=%b valid=%b expected addr=%h req=1 valid=0", i, imem_addr, imem_req, instr_valid, expected); end
         word = 16'($urandom);
         pl = 1'($urandom); jb = 1'($urandom); bc = 1'($urandom);
         z  = 1'($urandom); n  = 1'($urandom); tgt = 16'($urandom);
         drive_fetch(word, $urandom_range(0, 3));
         tests_run++; if (instr !== word || instr_valid !== 1'b1 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL rand_issue[%0d]: instr=%h valid=%b req=%b expected instr=%h valid=1 req=0", i, instr, instr_valid, imem_req, word); end
         drive_issue(pl, jb, bc, z, n, tgt, $urandom_range(0, 3));
         model_pc = model_next_pc(expected, word, pl, jb, bc, z, n, tgt);
         exp_q.push_back(model_pc);
      end
      expected = exp_q.pop_front();
      tests_run++; if (imem_addr !== expected) begin tests_failed++; $display("FAIL rand_final: got %h expected %h", imem_addr, expected); end
   endtask

   initial begin
      reset = 1'b1; imem_ack = 1'b0; imem_data = 16'h0000; instr_ready = 1'b0;
      PL = 1'b0; JB = 1'b0; BC = 1'b0; Z = 1'b0; N = 1'b0; bus_a = 16'h0000;
      test_reset();
      test_linear();
      test_brz();
      test_brn_wrap();
      test_jmp();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
